// File: rtl/hack_pc.sv
// Hack program counter with a one-cycle boot state, stall, and increment-wrap pulse.
// Define HACK_PC_HISTORY_EN to add a circular buffer of recent jump-source addresses.
module hack_pc #(
    parameter int                 WIDTH      = 16,
    parameter logic [WIDTH-1:0]   RESET_VEC  = '0,
    parameter int                 HIST_DEPTH = 4,
    localparam int                HSEL_W     = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic              inc,
    input  logic              reset,
    input  logic              stall,
    output logic [WIDTH-1:0]  out,
    output logic              booting,
    output logic              wrap,
    input  logic [HSEL_W-1:0] hist_sel,
    output logic [WIDTH-1:0]  hist_out
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic             jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

    // wrap_d defaults low so that every edge other than an all-ones increment clears the pulse.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
        jump    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (reset) begin
                    pc_d = RESET_VEC;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (load) begin
                    pc_d = in;
                    jump = 1'b1;
                end else if (inc) begin
                    pc_d   = pc_q + WIDTH'(1);
                    wrap_d = &pc_q;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign out     = pc_q;
    assign booting = (state_q == BOOT);
    assign wrap    = wrap_q;

`ifdef HACK_PC_HISTORY_EN
    logic [WIDTH-1:0]  hist_q [HIST_DEPTH];
    logic [HSEL_W-1:0] hist_wr_ptr_q;
    logic [HSEL_W-1:0] hist_rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            hist_wr_ptr_q <= '0;
        end else if (jump) begin
            hist_q[hist_wr_ptr_q] <= pc_q;
            hist_wr_ptr_q         <= hist_wr_ptr_q + HSEL_W'(1);
        end
    end

    // Power-of-two depth lets the index arithmetic wrap naturally.
    assign hist_rd_idx = hist_wr_ptr_q - HSEL_W'(1) - hist_sel;
    assign hist_out    = hist_q[hist_rd_idx];
`else
    logic unused_hist;
    assign unused_hist = jump ^ (^hist_sel);
    assign hist_out    = '0;
`endif

endmodule

// File: tb/tb_hack_pc.sv
// Directed testbench for hack_pc: boot, priority, stall, wrap, async reset, history.
module tb_hack_pc;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic             load, inc, reset, stall;
    logic [WIDTH-1:0] out;
    logic             booting, wrap;
    logic [1:0]       hist_sel;
    logic [WIDTH-1:0] hist_out;

    int n_checks = 0;
    int n_fail   = 0;

    hack_pc #(.WIDTH(WIDTH), .RESET_VEC(16'h0000), .HIST_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .load     (load),
        .inc      (inc),
        .reset    (reset),
        .stall    (stall),
        .out      (out),
        .booting  (booting),
        .wrap     (wrap),
        .hist_sel (hist_sel),
        .hist_out (hist_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic i, input logic r, input logic s,
                         input logic [WIDTH-1:0] d);
        load  = l;
        inc   = i;
        reset = r;
        stall = s;
        in    = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        hist_sel = 2'd0;
        drive(0, 0, 0, 0, 16'h0000);
        #2;
        check("rst_out", 32'(out), 32'h0000);
        check("rst_booting", 32'(booting), 32'd1);
        check("rst_wrap", 32'(wrap), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Boot edge, then load 0x0042.
        drive(1, 0, 0, 0, 16'h0042);
        step();
        check("boot1_out", 32'(out), 32'h0000);
        check("boot1_booting", 32'(booting), 32'd0);
        step();
        check("load42", 32'(out), 32'h0042);

        // Asynchronous reset mid-cycle.
        drive(0, 0, 0, 0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out", 32'(out), 32'h0000);
        check("async_booting", 32'(booting), 32'd1);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 16'h1234);
        step();
        check("boot_ignore_load", 32'(out), 32'h0000);
        check("boot_done", 32'(booting), 32'd0);
        step();
        check("load1234", 32'(out), 32'h1234);

        // Priority.
        drive(1, 0, 0, 0, 16'h0010);
        step();
        check("load10", 32'(out), 32'h0010);
        drive(1, 1, 1, 1, 16'h0555);
        step();
        check("prio_reset", 32'(out), 32'h0000);
        drive(1, 1, 0, 0, 16'h0777);
        step();
        check("prio_load", 32'(out), 32'h0777);
        drive(0, 1, 0, 0, 16'h0000);
        step();
        check("prio_inc", 32'(out), 32'h0778);
        drive(0, 0, 0, 0, 16'h0000);
        step();
        check("prio_hold", 32'(out), 32'h0778);

        // Stall.
        drive(1, 0, 0, 0, 16'h0100);
        step();
        check("load100", 32'(out), 32'h0100);
        drive(1, 0, 0, 1, 16'h0200);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_hold", 32'(out), 32'h0100);
        end
        drive(0, 1, 0, 0, 16'h0000);
        step();
        check("stall_release_inc", 32'(out), 32'h0101);

        // Wrap.
        drive(1, 0, 0, 0, 16'hFFFE);
        step();
        check("loadFFFE", 32'(out), 32'hFFFE);
        drive(0, 1, 0, 0, 16'h0000);
        step();
        check("incFFFF", 32'(out), 32'hFFFF);
        check("wrap_pre", 32'(wrap), 32'd0);
        step();
        check("inc_wrap_out", 32'(out), 32'h0000);
        check("wrap_pulse", 32'(wrap), 32'd1);
        step();
        check("inc_after_wrap", 32'(out), 32'h0001);
        check("wrap_clear", 32'(wrap), 32'd0);

        // Wrap cleared by a stall edge.
        drive(1, 0, 0, 0, 16'hFFFF);
        step();
        drive(0, 1, 0, 0, 16'h0000);
        step();
        check("wrap_pulse2", 32'(wrap), 32'd1);
        drive(0, 1, 0, 1, 16'h0000);
        step();
        check("wrap_clear_stall", 32'(wrap), 32'd0);
        check("stall_out", 32'(out), 32'h0000);

        // Wrap pulse cleared asynchronously.
        drive(1, 0, 0, 0, 16'hFFFF);
        step();
        drive(0, 1, 0, 0, 16'h0000);
        step();
        check("wrap_pulse3", 32'(wrap), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wrap_clear", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("count_1", 32'(out), 32'h0001);
        step();
        check("count_2", 32'(out), 32'h0002);

        // Async reset while incrementing, then one boot cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_run_out", 32'(out), 32'h0000);
        check("async_run_booting", 32'(booting), 32'd1);
        #1;
        rst_n = 1'b1;
        step();
        check("reboot_hold", 32'(out), 32'h0000);
        step();
        check("reboot_inc", 32'(out), 32'h0001);

        // Jump history: jump sources 0x0001, 0x0011, 0x0021, 0x0031, 0x0041.
        for (int j = 1; j <= 5; j++) begin
            drive(1, 0, 0, 0, 16'(j * 16));
            step();
            drive(0, 1, 0, 0, 16'h0000);
            step();
        end
        check("hist_walk_out", 32'(out), 32'h0051);
        drive(0, 0, 0, 0, 16'h0000);
`ifdef HACK_PC_HISTORY_EN
        hist_sel = 2'd0; #1; check("hist0", 32'(hist_out), 32'h0041);
        hist_sel = 2'd1; #1; check("hist1", 32'(hist_out), 32'h0031);
        hist_sel = 2'd2; #1; check("hist2", 32'(hist_out), 32'h0021);
        hist_sel = 2'd3; #1; check("hist3", 32'(hist_out), 32'h0011);
`else
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            #1;
            check("hist_tied0", 32'(hist_out), 32'h0000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_pc.md
Name: hack_pc

Overview:
- Hack program counter, built as the word-wide stage directly downstream of the 1-bit load-enabled storage cell.
- Holds the current instruction address and updates it each clock by sync-reset, jump-load, increment or hold, following Hack PC priority.
- Adds a one-cycle boot state after async reset, a stall input, and a wrap indicator for the instruction-fetch stage that consumes `out`.

Parameters:
- WIDTH, 16: address width in bits.
- RESET_VEC, 0: address loaded on async reset and on sync `reset`.
- HIST_DEPTH, 4: jump-history entries (power of 2). Only used with HACK_PC_HISTORY_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  jump target.
- load  input  1  load `in` next edge.
- inc  input  1  increment next edge.
- reset  input  1  synchronous Hack reset to RESET_VEC.
- stall  input  1  freeze counter.
- out  output  WIDTH  current address (registered).
- booting  output  1  high while in BOOT state.
- wrap  output  1  registered one-cycle pulse: last update was an increment from all-ones to 0.
- hist_sel  input  log2(HIST_DEPTH)  history read index (feature only).
- hist_out  output  WIDTH  history read data (feature only).

Behaviour:
- Reset is asynchronous, active-low: rst_n=0 immediately forces out=RESET_VEC, booting=1, wrap=0, state=BOOT; with the feature, all history entries=0 and hist_wr_ptr=0.
- rst_n is released asynchronously; all following behaviour is on the rising edge of clk.
- States are BOOT and RUN.
- BOOT: the first edge after rst_n release moves to RUN. All inputs are ignored on that edge. out stays RESET_VEC, wrap=0.
- booting is 1 in BOOT and 0 in RUN (Moore output).
- RUN, next out by priority:
  1. reset=1 gives out=RESET_VEC. This overrides stall.
  2. Otherwise stall=1 holds out; load and inc are dropped.
  3. Otherwise load=1 gives out=in, and inc is ignored.
  4. Otherwise inc=1 gives out=out+1, modulo 2^WIDTH.
  5. Otherwise hold.
- Latency is one edge: a new value is visible on out after the edge where it is sampled.
- wrap: set to 1 for exactly one cycle after an edge that took the inc path with out=all-ones. Any other edge clears it, including reset, load and stall edges.
- Simultaneous reset+load+inc+stall: reset wins.
- load with in==out behaves as a normal load: counts as a jump and is recorded in history.
- rst_n asserted mid-operation: immediate return to BOOT regardless of clk.

Optional Feature:
- Macro HACK_PC_HISTORY_EN.
- Defined:
  - A HIST_DEPTH-entry circular buffer records the pre-jump out value on every RUN edge that takes the load path.
  - Entries are written at hist_wr_ptr, and hist_wr_ptr then increments, wrapping modulo HIST_DEPTH. The oldest entry is overwritten when full.
  - hist_out is the combinational read of entry (hist_wr_ptr-1-hist_sel) mod HIST_DEPTH: hist_sel=0 is the most recent jump source.
  - Sync reset, stall and BOOT edges do not write.
- Undefined:
  - hist_sel and hist_out ports are still present.
  - hist_out is tied to 0, hist_sel is ignored, and no history storage is synthesized.

Test Plan:
- Async reset/boot: rst_n=0 mid-cycle with out=0x0042 -> out=0x0000 and booting=1 immediately. Release, then apply load=1, in=0x1234 on the first edge -> out stays 0x0000, booting=0. Second edge -> out=0x1234.
- Priority: RUN, out=0x0010. Edge with reset=1, load=1, inc=1, stall=1 -> 0x0000. Edge with load=1, inc=1, in=0x0777 -> 0x0777. Edge with inc=1 -> 0x0778. Edge with all low -> 0x0778.
- Stall: out=0x0100, stall=1, load=1, in=0x0200, three edges -> out stays 0x0100. Drop stall, edge with inc=1 -> 0x0101.
- Wrap: load 0xFFFE, then inc two edges -> out=0xFFFF with wrap=0, then out=0x0000 with wrap=1. Next edge with inc=1 -> out=0x0001, wrap=0.
- Async reset mid-run: while incrementing, assert rst_n=0 between edges -> out=RESET_VEC without waiting for clk, wrap=0. Release -> one BOOT cycle before counting resumes.
- History (HACK_PC_HISTORY_EN): from 0x0000, perform loads from addresses 0x0001, 0x0011, 0x0021, 0x0031, 0x0041, reaching each by a load plus one inc. hist_sel=0 -> 0x0041, hist_sel=3 -> 0x0011; 0x0001 is overwritten. Without the macro, hist_out=0 for all hist_sel.
